// File: rtl/nbody_pkg.sv
// Shared constants and types for the N-body bus controller.
package nbody_pkg;

    // Register offsets (low three bits of a register-space address)
    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_NBODIES = 3'd2;
    localparam logic [2:0] REG_NSTEPS  = 3'd3;
    localparam logic [2:0] REG_STEPCNT = 3'd4;

    // CTRL / STATUS bit positions
    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;
    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;

    // Each body occupies an 8-word slot; only the first FIELDS words are used
    localparam int SLOT_STRIDE = 8;

    typedef enum logic [2:0] {F_X, F_Y, F_VX, F_VY, F_M} field_e;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FIN} state_e;

endpackage

// File: rtl/nbody_bus_ctrl_if.sv
// Avalon-style slave bus bundle for the N-body controller.
interface nbody_bus_ctrl_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64
);
    logic                  chipselect;
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (output chipselect, read, write, addr, write_data, input read_data);
    modport slave  (input chipselect, read, write, addr, write_data, output read_data);
endinterface

// File: rtl/nbody_body_ram.sv
// Body-state RAM: one write port, one synchronous read port, no reset.
// A read and write to the same address in one cycle returns the old word.
module nbody_body_ram #(
    parameter int DEPTH = 4096,
    parameter int DW    = 64,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    // Write and registered read share one edge; read sees pre-write contents
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/nbody_bus_ctrl.sv
// N-body accelerator bus slave: register file, body RAM arbitration and
// the step sequencer that drives the compute engine for NUM_STEPS passes.
module nbody_bus_ctrl
    import nbody_pkg::*;
#(
    parameter int BODIES     = 512,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int FIELDS     = 5,
    parameter int BIDX_W     = $clog2(BODIES)
) (
    input  logic                  clk,
    input  logic                  rst,
    nbody_bus_ctrl_if.slave       bus,
    output logic                  irq,
    output logic                  eng_start,
    output logic                  eng_abort,
    output logic [BIDX_W:0]       eng_nbodies,
    input  logic                  eng_done,
    input  logic [BIDX_W+2:0]     eng_rd_addr,
    output logic [DATA_WIDTH-1:0] eng_rd_data,
    input  logic                  eng_wr_en,
    input  logic [BIDX_W+2:0]     eng_wr_addr,
    input  logic [DATA_WIDTH-1:0] eng_wr_data
);
    localparam int RAM_AW = BIDX_W + 3;

    state_e                state, state_d;
    logic [BIDX_W:0]       num_bodies;
    logic [31:0]           num_steps, step_count, cnt_next;
    logic                  done, busy;
    logic                  launch_clr, cnt_inc, set_done;

    logic                  bus_wr, bus_rd, is_ram, fld_ok, reg_wr;
    logic                  ctrl_wr, start_req, abort_req;
    logic [2:0]            off;
    logic [DATA_WIDTH-1:0] wd, reg_rdata, reg_q, hold_q, ram_q;
    logic                  rd_pend, rd_ram;

    logic                  ram_we;
    logic [RAM_AW-1:0]     ram_waddr, ram_raddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  unused_ok;

    // Address bits between the RAM index and the space-select MSB are don't-care
    assign unused_ok = ^{bus.addr, 1'b0};

    assign wd        = bus.write_data;
    assign busy      = (state != S_IDLE);
    assign bus_wr    = bus.chipselect & bus.write;
    assign bus_rd    = bus.chipselect & bus.read & ~bus.write;  // write wins
    assign is_ram    = bus.addr[ADDR_WIDTH-1];
    assign off       = bus.addr[2:0];
    assign fld_ok    = (off < 3'(FIELDS));
    assign reg_wr    = bus_wr & ~is_ram;
    assign ctrl_wr   = reg_wr & (off == REG_CTRL);
    assign abort_req = ctrl_wr & wd[CTRL_ABORT];
    assign start_req = ctrl_wr & wd[CTRL_START] & ~wd[CTRL_ABORT];
    assign cnt_next  = step_count + 32'd1;

    assign irq         = done;
    assign eng_nbodies = num_bodies;
    assign eng_rd_data = ram_q;

    // Sequencer next state and engine strobes; abort overrides every busy state
    always_comb begin
        state_d    = state;
        eng_start  = 1'b0;
        eng_abort  = 1'b0;
        launch_clr = 1'b0;
        cnt_inc    = 1'b0;
        set_done   = 1'b0;
        if (abort_req && busy) begin
            eng_abort = 1'b1;
            state_d   = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start_req) begin
                    state_d    = S_LAUNCH;
                    launch_clr = 1'b1;
                end
                S_LAUNCH: if (num_bodies == '0 || num_steps == '0) begin
                    state_d  = S_FIN;
                    set_done = 1'b1;
                end else begin
                    eng_start = 1'b1;
                    state_d   = S_WAIT;
                end
                S_WAIT: if (eng_done) begin
                    cnt_inc = 1'b1;
                    if (cnt_next == num_steps) begin
                        state_d  = S_FIN;
                        set_done = 1'b1;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
                S_FIN:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Sequencer state, step counter, done flag and run-parameter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            num_bodies <= '0;
            num_steps  <= '0;
            step_count <= '0;
            done       <= 1'b0;
        end else begin
            state <= state_d;
            if (launch_clr)   step_count <= '0;
            else if (cnt_inc) step_count <= cnt_next;
            // done is set on entry to FIN so it wins over a same-cycle clear
            if (set_done)                                         done <= 1'b1;
            else if (launch_clr)                                  done <= 1'b0;
            else if (reg_wr && off == REG_STATUS && wd[STAT_DONE]) done <= 1'b0;
            if (reg_wr && !busy && off == REG_NBODIES)
                num_bodies <= (wd > DATA_WIDTH'(BODIES)) ? (BIDX_W+1)'(BODIES) : wd[BIDX_W:0];
            if (reg_wr && !busy && off == REG_NSTEPS)
                num_steps <= wd[31:0];
        end
    end

    // Register readback value, captured on the read strobe
    always_comb begin
        reg_rdata = '0;
        case (off)
            REG_STATUS:  reg_rdata = DATA_WIDTH'({done, busy});
            REG_NBODIES: reg_rdata = DATA_WIDTH'(num_bodies);
            REG_NSTEPS:  reg_rdata = DATA_WIDTH'(num_steps);
            REG_STEPCNT: reg_rdata = DATA_WIDTH'(step_count);
            default:     reg_rdata = '0;
        endcase
    end

    // Read pipeline: one cycle after the strobe pick RAM or register data,
    // otherwise hold the last value returned
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend <= 1'b0;
            rd_ram  <= 1'b0;
            reg_q   <= '0;
            hold_q  <= '0;
        end else begin
            rd_pend <= bus_rd;
            hold_q  <= bus.read_data;
            if (bus_rd) begin
                rd_ram <= is_ram & ~busy & fld_ok;
                reg_q  <= is_ram ? '0 : reg_rdata;
            end
        end
    end

    assign bus.read_data = !rd_pend ? hold_q : (rd_ram ? ram_q : reg_q);

    // RAM ports belong to the bus when idle and to the engine while busy
    assign ram_we    = busy ? eng_wr_en   : (bus_wr & is_ram & fld_ok);
    assign ram_waddr = busy ? eng_wr_addr : bus.addr[RAM_AW-1:0];
    assign ram_wdata = busy ? eng_wr_data : wd;
    assign ram_raddr = busy ? eng_rd_addr : bus.addr[RAM_AW-1:0];

    nbody_body_ram #(
        .DEPTH (BODIES * SLOT_STRIDE),
        .DW    (DATA_WIDTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );
endmodule

// File: tb/tb_nbody_bus_ctrl.sv
// Directed bench for nbody_bus_ctrl with a small engine model.
module tb_nbody_bus_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        irq, eng_start, eng_abort, eng_done;
    logic [9:0]  eng_nbodies;
    logic [11:0] eng_rd_addr, eng_wr_addr;
    logic [63:0] eng_rd_data, eng_wr_data;
    logic        eng_wr_en;

    int          n_chk = 0, n_fail = 0;
    int          n_start = 0, n_abort = 0, timer = 0;
    logic [9:0]  nb_seen = '0;
    logic [63:0] rd_cap = '0;
    logic        idle_wr_req;
    logic [63:0] d;

    always #5 clk = ~clk;

    nbody_bus_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(64)) bus ();

    nbody_bus_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .irq         (irq),
        .eng_start   (eng_start),
        .eng_abort   (eng_abort),
        .eng_nbodies (eng_nbodies),
        .eng_done    (eng_done),
        .eng_rd_addr (eng_rd_addr),
        .eng_rd_data (eng_rd_data),
        .eng_wr_en   (eng_wr_en),
        .eng_wr_addr (eng_wr_addr),
        .eng_wr_data (eng_wr_data)
    );

    // Engine model: eng_done 10 cycles after each eng_start; on the very first
    // pass it writes word 8 and reads word 0x1A through the engine ports.
    always @(posedge clk) begin
        logic dn;
        dn = 1'b0;
        if (!rst) timer = 0;
        else begin
            if (eng_abort) begin n_abort++; timer = 0; end
            if (eng_start) begin n_start++; nb_seen = eng_nbodies; timer = 10; end
            else if (timer > 0) begin timer--; dn = (timer == 0); end
        end
        #1;
        eng_done  = dn;
        eng_wr_en = (n_start == 1 && timer == 7) || idle_wr_req;
        if (n_start == 1 && timer == 6) rd_cap = eng_rd_data;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [63:0] v);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.read = 1'b0;
        bus.addr = a; bus.write_data = v;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [63:0] v);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.write = 1'b0; bus.addr = a;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.read = 1'b0;
        v = bus.read_data;
    endtask

    task automatic wait_irq(input int max);
        int k = 0;
        while (irq !== 1'b1 && k < max) begin @(negedge clk); k++; end
        if (irq !== 1'b1) chk("irq_timeout", 64'(irq), 64'd1);
    endtask

    task automatic wait_starts(input int target, input int max);
        int k = 0;
        while (n_start < target && k < max) begin @(negedge clk); k++; end
        if (n_start < target) chk("start_timeout", 64'(n_start), 64'(target));
    endtask

    initial begin
        rst = 1'b0;
        bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        bus.addr = '0; bus.write_data = '0;
        eng_rd_addr = 12'h01A; eng_wr_addr = 12'h008; eng_wr_data = 64'h55;
        idle_wr_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_rdata", bus.read_data, 64'd0);
        chk("rst_eng_start", 64'(eng_start), 64'd0);
        rst = 1'b1;
        bus_read(16'h0001, d); chk("rst_status", d, 64'd0);
        bus_read(16'h0002, d); chk("rst_nbodies", d, 64'd0);
        bus_read(16'h0004, d); chk("rst_stepcnt", d, 64'd0);

        // RAM access while idle
        bus_write(16'h801A, 64'hDEAD);
        bus_read(16'h801A, d); chk("ram_rd", d, 64'hDEAD);
        bus_write(16'h801E, 64'h1234);
        bus_read(16'h801E, d); chk("ram_field6", d, 64'd0);
        bus_write(16'h8008, 64'h11);
        idle_wr_req = 1'b1;
        repeat (3) @(negedge clk);
        idle_wr_req = 1'b0;
        bus_read(16'h8008, d); chk("eng_wr_idle", d, 64'h11);

        // Three-pass run
        bus_write(16'h0002, 64'd4);
        bus_write(16'h0003, 64'd3);
        bus_write(16'h0000, 64'd1);
        bus_write(16'h801A, 64'hBEEF);
        bus_read(16'h801A, d); chk("ram_rd_busy", d, 64'd0);
        wait_irq(300);
        chk("run_starts", 64'(n_start), 64'd3);
        chk("run_nbodies", 64'(nb_seen), 64'd4);
        bus_read(16'h0004, d); chk("run_stepcnt", d, 64'd3);
        bus_read(16'h0001, d); chk("run_status", d, 64'd2);
        chk("run_irq", 64'(irq), 64'd1);
        chk("eng_rd", rd_cap, 64'hDEAD);
        bus_read(16'h801A, d); chk("ram_kept", d, 64'hDEAD);
        bus_read(16'h8008, d); chk("eng_wr_run", d, 64'h55);
        bus_write(16'h0001, 64'h2);
        chk("irq_clr", 64'(irq), 64'd0);

        // Clamp and zero-step run
        bus_write(16'h0002, 64'd1000);
        bus_read(16'h0002, d); chk("nb_clamp", d, 64'd512);
        bus_write(16'h0003, 64'd0);
        bus_write(16'h0000, 64'd1);
        chk("zs_irq_early", 64'(irq), 64'd0);
        @(negedge clk);
        chk("zs_irq", 64'(irq), 64'd1);
        chk("zs_starts", 64'(n_start), 64'd3);
        bus_write(16'h0001, 64'h2);

        // Abort during the second WAIT
        bus_write(16'h0002, 64'd4);
        bus_write(16'h0003, 64'd3);
        bus_write(16'h0000, 64'd1);
        wait_starts(5, 200);
        repeat (3) @(negedge clk);
        bus_write(16'h0000, 64'h2);
        chk("abort_pulse", 64'(n_abort), 64'd1);
        bus_read(16'h0001, d); chk("abort_status", d, 64'd0);
        bus_read(16'h0004, d); chk("abort_stepcnt", d, 64'd1);
        repeat (30) @(negedge clk);
        chk("abort_no_relaunch", 64'(n_start), 64'd5);
        chk("abort_irq", 64'(irq), 64'd0);
        bus_write(16'h0000, 64'h2);
        chk("idle_abort", 64'(n_abort), 64'd1);
        bus_write(16'h0000, 64'h3);
        repeat (3) @(negedge clk);
        chk("start_abort", 64'(n_start), 64'd5);
        bus_read(16'h0001, d); chk("start_abort_status", d, 64'd0);

        // Asynchronous reset mid-WAIT, then a normal run
        bus_read(16'h0002, d); chk("pre_rst_nb", d, 64'd4);
        bus_write(16'h0000, 64'd1);
        wait_starts(6, 50);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_rdata", bus.read_data, 64'd0);
        chk("arst_nbodies", 64'(eng_nbodies), 64'd0);
        chk("arst_irq", 64'(irq), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus_write(16'h0002, 64'd2);
        bus_write(16'h0003, 64'd2);
        bus_write(16'h0000, 64'd1);
        wait_irq(200);
        chk("post_rst_starts", 64'(n_start), 64'd8);
        bus_read(16'h0004, d); chk("post_rst_stepcnt", d, 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
